jtframe_lfbuf_bram_nbuf: RTL and testbench

Parametrised successor to the line-frame-buffer BRAM controller. Stores object/tile lines produced by a line buffer into an on-chip BRAM frame store. Reads them back during H blank for the scan-out line buffer. Adds generic data width, 2- or 3-page buffering with internal page rotation, read-latency-correct scan write strobes, and detection of dropped lines.

---
 rtl/jtframe_lfbuf_pkg.sv | 12 +
 rtl/jtframe_lfbuf_hwin.sv | 27 ++
 rtl/jtframe_lfbuf_bram_nbuf.sv | 159 +++++++++++++++
 tb/tb_jtframe_lfbuf_bram_nbuf.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jtframe_lfbuf_pkg.sv
// jtframe_lfbuf_pkg: state encoding, page-width helper and status addresses shared by the lfbuf controllers
package jtframe_lfbuf_pkg;
   typedef enum logic [1:0] {IDLE, READ, WRITE} lfbuf_st_t;
   localparam logic [7:0] ST_FLAGS = 8'd0;
   localparam logic [7:0] ST_PAGES = 8'd1;
   localparam logic [7:0] ST_DROPS = 8'd2;
   localparam logic [7:0] ST_LNV   = 8'd3;
   localparam logic [7:0] ST_VREN  = 8'd4;
   function automatic int page_w(input int nbuf);
      return nbuf == 2 ? 1 : 2;
   endfunction
endpackage

// File: rtl/jtframe_lfbuf_hwin.sv
// jtframe_lfbuf_hwin: measures blank length and the write window of each line in pixel units
module jtframe_lfbuf_hwin #(parameter int HW = 9) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          lhbl,
   output logic [HW-1:0] hcnt,
   output logic [HW-1:0] hlim,
   output logic          hs_fall
);
   logic          lhbl_l;
   logic [HW-1:0] hblen;
   assign hs_fall = pxl_cen & lhbl_l & ~lhbl;
   always_ff @(posedge clk) begin
      if (rst) begin
         lhbl_l <= 1'b0;
         hcnt   <= '0;
         hblen  <= '0;
         hlim   <= '0;
      end else if (pxl_cen) begin
         lhbl_l <= lhbl;
         hcnt   <= hs_fall ? '0 : hcnt + 1'b1;
         if (hs_fall) hlim <= hcnt - hblen;
         if (lhbl & ~lhbl_l) hblen <= hcnt;
      end
   end
endmodule

// File: rtl/jtframe_lfbuf_bram_nbuf.sv
// jtframe_lfbuf_bram_nbuf: stores finished lines in a paged BRAM frame and replays them during H blank
// Optional registered status port enabled by defining JTFRAME_LFBUF_STATUS_EN
module jtframe_lfbuf_bram_nbuf
   import jtframe_lfbuf_pkg::*;
#(
   parameter int DW   = 16,
   parameter int VW   = 8,
   parameter int HW   = 9,
   parameter int NBUF = 2,
   parameter logic [DW-1:0] CLRV = '0,
   localparam int PW  = page_w(NBUF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          lhbl,
   input  logic          vs,
   input  logic          ln_done,
   input  logic [VW-1:0] ln_v,
   input  logic [VW-1:0] vrender,
   output logic [HW-1:0] fb_addr,
   input  logic [DW-1:0] fb_din,
   output logic          fb_clr,
   output logic [DW-1:0] fb_clrv,
   output logic          fb_done,
   output logic          ln_drop,
   output logic [DW-1:0] fb_dout,
   output logic [HW-1:0] rd_addr,
   output logic          scr_we,
   output logic          line,
   output logic [PW-1:0] wr_page,
   output logic [PW-1:0] rd_page,
   input  logic [7:0]    st_addr,
   output logic [7:0]    st_dout
);
   localparam int AW = PW + VW + HW;
   localparam logic [PW-1:0] LASTPG = PW'(NBUF - 1);

   lfbuf_st_t          st, st_nx;
   logic [HW:0]        cnt, cnt_nx;
   logic [HW-1:0]      hcnt, hlim, clr_h, wh;
   logic               hs_fall, vs_l, ln_done_l, do_wr, wr_q;
   logic               vs_rise, ln_rise, start_rd, start_wr, rd_en, last, wr_last;
   logic [VW-1:0]      wr_v;
   logic [PW+VW-1:0]   rrow, wrow;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem [0:2**AW-1];

   jtframe_lfbuf_hwin #(.HW(HW)) u_hwin (
      .clk     (clk),
      .rst     (rst),
      .pxl_cen (pxl_cen),
      .lhbl    (lhbl),
      .hcnt    (hcnt),
      .hlim    (hlim),
      .hs_fall (hs_fall)
   );

   // cnt runs one step past the line so the delayed strobe/write of the last word still lands in-state
   assign last     = cnt[HW];
   assign wr_last  = (st == WRITE) & last;
   assign rd_en    = (st == READ) & ~last;
   assign vs_rise  = pxl_cen & vs & ~vs_l;
   assign ln_rise  = ln_done & ~ln_done_l;
   assign fb_clrv  = CLRV;
   assign fb_addr  = fb_clr ? clr_h : (st == WRITE) ? cnt[HW-1:0] : '0;
   assign mem_addr = rd_en ? {rrow, cnt[HW-1:0]} : {wrow, wh};

   always_comb begin
      start_rd = (st == IDLE) & hs_fall;
      start_wr = (st == IDLE) & ~hs_fall & do_wr & ~fb_clr & lhbl & (hcnt < hlim);
      st_nx    = start_rd ? READ : start_wr ? WRITE : (st != IDLE && last) ? IDLE : st;
      cnt_nx   = (st == IDLE) ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         cnt       <= '0;
         vs_l      <= 1'b0;
         ln_done_l <= 1'b0;
         do_wr     <= 1'b0;
         wr_v      <= '0;
         ln_drop   <= 1'b0;
         wr_page   <= '0;
         rd_page   <= LASTPG;
         rrow      <= '0;
         wrow      <= '0;
         wr_q      <= 1'b0;
         wh        <= '0;
         scr_we    <= 1'b0;
         rd_addr   <= '0;
         fb_done   <= 1'b0;
         line      <= 1'b0;
         fb_clr    <= 1'b0;
         clr_h     <= '0;
      end else begin
         st        <= st_nx;
         cnt       <= cnt_nx;
         ln_done_l <= ln_done;
         if (pxl_cen) vs_l <= vs;
         if (vs_rise) begin
            rd_page <= wr_page;
            wr_page <= (wr_page == LASTPG) ? '0 : wr_page + 1'b1;
         end
         ln_drop <= ln_rise & do_wr & ~start_wr;
         if (ln_rise) begin
            do_wr <= 1'b1;
            wr_v  <= ln_v;
         end else if (start_wr) begin
            do_wr <= 1'b0;
         end
         if (start_rd) rrow <= {rd_page, vrender};
         if (start_wr) wrow <= {wr_page, wr_v};
         wr_q    <= (st == WRITE) & ~last;
         wh      <= cnt[HW-1:0];
         scr_we  <= rd_en;
         rd_addr <= rd_en ? cnt[HW-1:0] : '0;
         fb_done <= wr_last;
         if (wr_last) begin
            line   <= ~line;
            fb_clr <= 1'b1;
            clr_h  <= '0;
         end else if (fb_clr) begin
            clr_h <= clr_h + 1'b1;
            if (&clr_h) fb_clr <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_q) mem[mem_addr] <= fb_din;
   end

   always_ff @(posedge clk) begin
      fb_dout <= (rst | ~rd_en) ? '0 : mem[mem_addr];
   end

`ifdef JTFRAME_LFBUF_STATUS_EN
   logic [7:0] drops;
   always_ff @(posedge clk) begin
      if (rst) begin
         drops   <= '0;
         st_dout <= '0;
      end else begin
         if (ln_drop & ~&drops) drops <= drops + 1'b1;
         st_dout <= st_addr == ST_FLAGS ? 8'({st, do_wr, fb_clr, line}) :
                    st_addr == ST_PAGES ? 8'({wr_page, rd_page}) :
                    st_addr == ST_DROPS ? drops :
                    st_addr == ST_LNV   ? 8'(ln_v) :
                    st_addr == ST_VREN  ? 8'(vrender) : 8'd0;
      end
   end
`else
   logic unused_st;
   assign unused_st = ^st_addr;
   assign st_dout   = '0;
`endif
endmodule

// File: tb/tb_jtframe_lfbuf_bram_nbuf.sv
// tb_jtframe_lfbuf_bram_nbuf: directed checks of line write, read-back, paging, drop detection and reset abort
module tb_jtframe_lfbuf_bram_nbuf;
   localparam int DW = 16, VW = 8, HW = 9;
`ifdef JTFRAME_LFBUF_STATUS_EN
   localparam logic [7:0] DROP_RD = 8'd1;
`else
   localparam logic [7:0] DROP_RD = 8'd0;
`endif

   logic clk = 0, rst = 1, pxl_cen = 0, lhbl = 1, vs = 0, ln_done = 0;
   logic [VW-1:0] ln_v = '0, vrender = '0;
   logic [DW-1:0] fb_din = '0, din_nx = '0, wpat = '0, rpat = '0;
   logic [7:0]    st_addr = '0;

   logic [HW-1:0] fb_addr, rd_addr, fb_addr3, rd_addr3;
   logic          fb_clr, fb_done, ln_drop, scr_we, line;
   logic          fb_clr3, fb_done3, ln_drop3, scr_we3, line3;
   logic [DW-1:0] fb_clrv, fb_dout, fb_clrv3, fb_dout3;
   logic [0:0]    wr_page, rd_page;
   logic [1:0]    wr_page3, rd_page3;
   logic [7:0]    st_dout, st_dout3;

   int vec = 0, miss = 0, cyc = 0, ph = 0;
   int done_n = 0, drop_n = 0, clr_run = 0, clr_len = 0, rd_run = 0, rd_len = 0;
   int rd_err = 0, seq_err = 0, z_err = 0, wr_n = 0, wr1 = 0, last_se = 0;
   bit rd_chk = 0;
   logic [HW-1:0] exp_ra = '0, prev_fa = '0;

   jtframe_lfbuf_bram_nbuf #(.DW(DW), .VW(VW), .HW(HW), .NBUF(2)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lhbl(lhbl), .vs(vs), .ln_done(ln_done),
      .ln_v(ln_v), .vrender(vrender), .fb_addr(fb_addr), .fb_din(fb_din), .fb_clr(fb_clr),
      .fb_clrv(fb_clrv), .fb_done(fb_done), .ln_drop(ln_drop), .fb_dout(fb_dout),
      .rd_addr(rd_addr), .scr_we(scr_we), .line(line), .wr_page(wr_page), .rd_page(rd_page),
      .st_addr(st_addr), .st_dout(st_dout)
   );

   jtframe_lfbuf_bram_nbuf #(.DW(DW), .VW(VW), .HW(HW), .NBUF(3)) dut3 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lhbl(lhbl), .vs(vs), .ln_done(ln_done),
      .ln_v(ln_v), .vrender(vrender), .fb_addr(fb_addr3), .fb_din(fb_din), .fb_clr(fb_clr3),
      .fb_clrv(fb_clrv3), .fb_done(fb_done3), .ln_drop(ln_drop3), .fb_dout(fb_dout3),
      .rd_addr(rd_addr3), .scr_we(scr_we3), .line(line3), .wr_page(wr_page3), .rd_page(rd_page3),
      .st_addr(st_addr), .st_dout(st_dout3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial forever begin
      @(posedge clk); #1;
      ph = (ph == 2) ? 0 : ph + 1;
      pxl_cen = (ph == 2);
   end

   // line buffer model: data for an address appears one clk after it is presented
   initial forever begin
      @(negedge clk);
      fb_din = din_nx;
      din_nx = DW'(fb_addr) ^ wpat;
   end

   always @(negedge clk) begin
      if (fb_done) done_n++;
      if (ln_drop) drop_n++;
      if (fb_clr) clr_run++;
      else if (clr_run != 0) begin clr_len = clr_run; clr_run = 0; end
      if (scr_we) begin
         if (rd_addr != exp_ra) seq_err++;
         if (rd_chk && fb_dout != (DW'(rd_addr) ^ rpat)) rd_err++;
         exp_ra++;
         rd_run++;
         last_se = cyc;
      end else begin
         if (fb_dout != '0) z_err++;
         if (rd_run != 0) begin rd_len = rd_run; rd_run = 0; end
         exp_ra = '0;
      end
      if (!fb_clr && fb_addr == 9'd1 && prev_fa == 9'd0) begin wr_n++; wr1 = cyc; end
      prev_fa = fb_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vec++;
      if (got !== want) begin
         miss++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic hline();
      lhbl = 0; tick(150);
      lhbl = 1; tick(1350);
   endtask

   task automatic vs_pulse(input logic wp, input logic rp, input logic [1:0] wp3, input logic [1:0] rp3);
      vs = 1; tick(6);
      vs = 0; tick(6);
      chk("wr_page", wr_page, wp);
      chk("rd_page", rd_page, rp);
      chk("wr_page3", wr_page3, wp3);
      chk("rd_page3", rd_page3, rp3);
   endtask

   task automatic ln_pulse(input logic [VW-1:0] v);
      ln_v = v; ln_done = 1; tick(3);
      ln_done = 0; tick(3);
   endtask

   initial begin
      tick(4);
      chk("rst_scr_we", scr_we, 0);
      chk("rst_fb_clr", fb_clr, 0);
      chk("rst_fb_done", fb_done, 0);
      chk("rst_line", line, 0);
      chk("rst_fb_dout", fb_dout, 0);
      chk("rst_wr_page", wr_page, 0);
      chk("rst_rd_page", rd_page, 1);
      chk("rst_rd_page3", rd_page3, 2);
      chk("rst_st_dout", st_dout, 0);
      chk("fb_clrv", fb_clrv, 0);
      rst = 0;
      tick(300);
      hline();
      hline();
      // blank start and ln_done edge on the same pixel-enabled clk
      while (!pxl_cen) tick(1);
      wpat = 16'hA5A5;
      lhbl = 0; ln_v = 8'd5; ln_done = 1; tick(4);
      ln_done = 0; tick(146);
      lhbl = 1; tick(1350);
      tick(100);
      chk("wr_after_rd", wr1 - last_se, 3);
      chk("wr_starts1", wr_n, 1);
      chk("done_cnt1", done_n, 1);
      chk("line1", line, 1);
      chk("clr_len", clr_len, 512);
      chk("drop0", drop_n, 0);
      vs_pulse(1'b1, 1'b0, 2'd1, 2'd0);
      vrender = 8'd5; rpat = 16'hA5A5; rd_err = 0; rd_chk = 1;
      hline();
      rd_chk = 0;
      chk("rd5_data", rd_err, 0);
      chk("rd5_len", rd_len, 512);
      chk("rd_seq", seq_err, 0);
      wpat = 16'h1234;
      ln_pulse(8'd7);
      ln_pulse(8'd9);
      chk("drop1", drop_n, 1);
      hline();
      tick(100);
      chk("done_cnt2", done_n, 2);
      chk("line2", line, 0);
      chk("wr_starts2", wr_n, 2);
      vs_pulse(1'b0, 1'b1, 2'd2, 2'd1);
      vrender = 8'd9; rpat = 16'h1234; rd_err = 0; rd_chk = 1;
      hline();
      rd_chk = 0;
      chk("rd9_data", rd_err, 0);
      chk("rd9_len", rd_len, 512);
      st_addr = 8'd2; tick(2);
      chk("st_drops", st_dout, DROP_RD);
      vs_pulse(1'b1, 1'b0, 2'd0, 2'd2);
      vs_pulse(1'b0, 1'b1, 2'd1, 2'd0);
      lhbl = 0; tick(150);
      lhbl = 1;
      ln_pulse(8'd3);
      for (int i = 0; i < 2000 && !(fb_addr == 9'd100 && !fb_clr); i++) tick(1);
      chk("wr_h100_reached", fb_addr, 100);
      rst = 1; tick(1);
      chk("mid_rst_fb_clr", fb_clr, 0);
      chk("mid_rst_fb_addr", fb_addr, 0);
      chk("mid_rst_fb_done", fb_done, 0);
      chk("mid_rst_scr_we", scr_we, 0);
      chk("mid_rst_wr_page", wr_page, 0);
      chk("mid_rst_rd_page", rd_page, 1);
      chk("mid_rst_wr_page3", wr_page3, 0);
      chk("mid_rst_rd_page3", rd_page3, 2);
      chk("mid_rst_st_dout", st_dout, 0);
      rst = 0;
      tick(300);
      hline();
      hline();
      tick(100);
      chk("no_wr_after_rst", wr_n, 3);
      chk("done_after_rst", done_n, 2);
      chk("drop_total", drop_n, 1);
      chk("dout_zero_idle", z_err, 0);
      chk("rd_seq_end", seq_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
